// File: rtl/pll_reconfig_ctrl.sv
// Avalon-MM reconfiguration sequencer for a Cyclone V PLL: shadows N/M/C settings,
// commits them as strobed bus transactions on START, waits for relock, and issues phase steps.
module pll_reconfig_ctrl #(
    parameter int unsigned C_FIFO_DEPTH = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned BUSY_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [63:0] reconfig_to_pll,
    input  logic [63:0] reconfig_from_pll
);

    localparam int unsigned PW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_BUSY,
        S_START_PLS,
        S_WAIT_LOCK,
        S_PHASE_PLS
    } state_t;

    state_t       state_q, state_d;
    logic         mode_q, mode_d;
    logic [17:0]  n_q, n_d;
    logic [17:0]  m_q, m_d;
    logic         n_dirty_q, n_dirty_d;
    logic         m_dirty_q, m_dirty_d;
    logic         timeout_q, timeout_d;
    logic         c_ovf_q, c_ovf_d;
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [22:0]  fifo_q [C_FIFO_DEPTH];
    logic [31:0]  rdata_q, rdata_d;

    logic         op_phase_q, op_phase_d;
    logic         started_q, started_d;
    logic [31:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]  lock_cnt_q, lock_cnt_d;
    logic [15:0]  ph_cnt_q, ph_cnt_d;
    logic         ph_dir_q, ph_dir_d;
    logic [4:0]   ph_sel_q, ph_sel_d;
    logic [31:0]  tx_data_q, tx_data_d;
    logic [5:0]   tx_addr_q, tx_addr_d;
    logic         stb_wr_q, stb_wr_d;
    logic         stb_start_q, stb_start_d;
    logic         stb_phase_q, stb_phase_d;

    logic         pll_busy, pll_locked;
    logic         idle, wait_req;
    logic         wr_acc, rd_acc, cfg_wr;
    logic         start_cmd, phase_cmd;
    logic         fifo_full, fifo_empty, push, push_ok, pop;
    logic         clr_n_dirty, clr_m_dirty, set_timeout;
    logic         unused_bits;

    assign pll_busy   = reconfig_from_pll[0];
    assign pll_locked = reconfig_from_pll[1];
    assign unused_bits = ^{avs_writedata[31:23], reconfig_from_pll[63:2]};

    assign idle     = (state_q == S_IDLE);
    assign wait_req = ~mode_q & ~idle;
    assign wr_acc   = avs_write & ~wait_req;
    assign rd_acc   = avs_read & ~wait_req;
    // MODE and STATUS stay writable while busy in polling mode; the rest only in IDLE.
    assign cfg_wr   = wr_acc & idle;

    assign start_cmd = cfg_wr && (avs_address == 3'd2);
    assign phase_cmd = cfg_wr && (avs_address == 3'd6) && (avs_writedata[15:0] != 16'd0);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = cfg_wr && (avs_address == 3'd5);
    assign push_ok    = push && (!fifo_full || pop);

    assign avs_waitrequest = wait_req;
    assign avs_readdata    = rdata_q;
    assign reconfig_to_pll = {23'd0, stb_phase_q, stb_start_q, stb_wr_q, tx_addr_q, tx_data_q};

    // Register file, sticky status and FIFO write side.
    always_comb begin
        mode_d    = mode_q;
        n_d       = n_q;
        m_d       = m_q;
        n_dirty_d = n_dirty_q;
        m_dirty_d = m_dirty_q;
        timeout_d = timeout_q;
        c_ovf_d   = c_ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rdata_d   = rdata_q;

        if (clr_n_dirty) n_dirty_d = 1'b0;
        if (clr_m_dirty) m_dirty_d = 1'b0;

        if (wr_acc) begin
            case (avs_address)
                3'd0: mode_d = avs_writedata[0];
                3'd1: begin
                    if (avs_writedata[2]) timeout_d = 1'b0;
                    if (avs_writedata[3]) c_ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end

        if (cfg_wr) begin
            case (avs_address)
                3'd3: begin
                    n_d       = avs_writedata[17:0];
                    n_dirty_d = 1'b1;
                end
                3'd4: begin
                    m_d       = avs_writedata[17:0];
                    m_dirty_d = 1'b1;
                end
                3'd5: begin
                    if (push_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
                    else         c_ovf_d  = 1'b1;
                end
                default: ;
            endcase
        end

        if (set_timeout) timeout_d = 1'b1;

        if (rd_acc) begin
            case (avs_address)
                3'd0:    rdata_d = {31'd0, mode_q};
                3'd1:    rdata_d = {28'd0, c_ovf_q, timeout_q, pll_locked, ~idle};
                3'd3:    rdata_d = {14'd0, n_q};
                3'd4:    rdata_d = {14'd0, m_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // Sequencer. Strobes are registered, so each *_PLS/ISSUE cycle launches a strobe
    // that appears on the bus during the first GAP cycle.
    always_comb begin
        state_d     = state_q;
        op_phase_d  = op_phase_q;
        started_d   = started_q;
        gap_cnt_d   = gap_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        ph_cnt_d    = ph_cnt_q;
        ph_dir_d    = ph_dir_q;
        ph_sel_d    = ph_sel_q;
        tx_data_d   = tx_data_q;
        tx_addr_d   = tx_addr_q;
        stb_wr_d    = 1'b0;
        stb_start_d = 1'b0;
        stb_phase_d = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;
        clr_n_dirty = 1'b0;
        clr_m_dirty = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    state_d    = S_ISSUE;
                    op_phase_d = 1'b0;
                    started_d  = 1'b0;
                end else if (phase_cmd) begin
                    state_d    = S_PHASE_PLS;
                    op_phase_d = 1'b1;
                    ph_cnt_d   = avs_writedata[15:0];
                    ph_sel_d   = avs_writedata[20:16];
                    ph_dir_d   = avs_writedata[21];
                end
            end
            S_ISSUE: begin
                gap_cnt_d = '0;
                if (n_dirty_q) begin
                    stb_wr_d    = 1'b1;
                    tx_addr_d   = 6'd3;
                    tx_data_d   = {14'd0, n_q};
                    clr_n_dirty = 1'b1;
                    state_d     = S_GAP;
                end else if (m_dirty_q) begin
                    stb_wr_d    = 1'b1;
                    tx_addr_d   = 6'd4;
                    tx_data_d   = {14'd0, m_q};
                    clr_m_dirty = 1'b1;
                    state_d     = S_GAP;
                end else if (!fifo_empty) begin
                    stb_wr_d  = 1'b1;
                    tx_addr_d = 6'd5;
                    tx_data_d = {9'd0, fifo_q[rd_ptr_q[PW-1:0]]};
                    pop       = 1'b1;
                    rd_ptr_d  = rd_ptr_q + (PW+1)'(1);
                    state_d   = S_GAP;
                end else begin
                    state_d = S_START_PLS;
                end
            end
            S_START_PLS: begin
                stb_start_d = 1'b1;
                started_d   = 1'b1;
                gap_cnt_d   = '0;
                state_d     = S_GAP;
            end
            S_PHASE_PLS: begin
                stb_phase_d = 1'b1;
                tx_addr_d   = 6'd6;
                tx_data_d   = {10'd0, ph_dir_q, ph_sel_q, 16'd0};
                ph_cnt_d    = ph_cnt_q - 16'd1;
                gap_cnt_d   = '0;
                state_d     = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q + 32'd1 >= BUSY_GAP) state_d = S_WAIT_BUSY;
                else                               gap_cnt_d = gap_cnt_q + 32'd1;
            end
            S_WAIT_BUSY: begin
                if (!pll_busy) begin
                    if (op_phase_q) begin
                        state_d = (ph_cnt_q == 16'd0) ? S_IDLE : S_PHASE_PLS;
                    end else if (started_q) begin
                        lock_cnt_d = '0;
                        state_d    = S_WAIT_LOCK;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d = S_IDLE;
                end else if (lock_cnt_q + 32'd1 >= LOCK_TIMEOUT) begin
                    set_timeout = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= avs_writedata[22:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            n_q         <= '0;
            m_q         <= '0;
            n_dirty_q   <= 1'b0;
            m_dirty_q   <= 1'b0;
            timeout_q   <= 1'b0;
            c_ovf_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdata_q     <= '0;
            op_phase_q  <= 1'b0;
            started_q   <= 1'b0;
            gap_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            ph_cnt_q    <= '0;
            ph_dir_q    <= 1'b0;
            ph_sel_q    <= '0;
            tx_data_q   <= '0;
            tx_addr_q   <= '0;
            stb_wr_q    <= 1'b0;
            stb_start_q <= 1'b0;
            stb_phase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            m_q         <= m_d;
            n_dirty_q   <= n_dirty_d;
            m_dirty_q   <= m_dirty_d;
            timeout_q   <= timeout_d;
            c_ovf_q     <= c_ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rdata_q     <= rdata_d;
            op_phase_q  <= op_phase_d;
            started_q   <= started_d;
            gap_cnt_q   <= gap_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            ph_cnt_q    <= ph_cnt_d;
            ph_dir_q    <= ph_dir_d;
            ph_sel_q    <= ph_sel_d;
            tx_data_q   <= tx_data_d;
            tx_addr_q   <= tx_addr_d;
            stb_wr_q    <= stb_wr_d;
            stb_start_q <= stb_start_d;
            stb_phase_q <= stb_phase_d;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a small PLL busy/lock model and a strobe monitor.
module tb_pll_reconfig_ctrl;

    localparam int unsigned LT = 300;
    localparam int unsigned BG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [63:0] reconfig_to_pll;
    logic [63:0] reconfig_from_pll;

    pll_reconfig_ctrl #(
        .C_FIFO_DEPTH(4),
        .LOCK_TIMEOUT(LT),
        .BUSY_GAP(BG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .avs_waitrequest  (avs_waitrequest),
        .reconfig_to_pll  (reconfig_to_pll),
        .reconfig_from_pll(reconfig_from_pll)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PLL model: busy for busy_len cycles after any strobe; relocks 20 cycles after start.
    int unsigned busy_len = 0;
    int unsigned busy_cnt = 0;
    int unsigned lk_cnt = 0;
    logic        locked_q = 1'b0;
    logic        lock_en = 1'b1;
    logic        any_stb;
    logic        busy;

    assign any_stb = |reconfig_to_pll[40:38];
    assign busy    = (busy_cnt != 0);
    assign reconfig_from_pll = {62'd0, locked_q & lock_en, busy};

    always @(posedge clk) begin
        if (any_stb) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (reconfig_to_pll[39]) begin
            locked_q <= 1'b0;
            lk_cnt   <= 20;
        end else if (lk_cnt > 1) begin
            lk_cnt <= lk_cnt - 1;
        end else if (lk_cnt == 1) begin
            lk_cnt   <= 0;
            locked_q <= 1'b1;
        end
    end

    typedef struct {
        int unsigned cyc;
        logic [2:0]  kind;
        logic [5:0]  addr;
        logic [31:0] data;
    } stb_t;

    stb_t        stq[$];
    int unsigned fq[$];
    logic        prev_stb = 1'b0;
    logic        prev_busy = 1'b0;

    always @(negedge clk) begin
        if (any_stb && !rst) begin
            stq.push_back('{cyc, reconfig_to_pll[40:38], reconfig_to_pll[37:32], reconfig_to_pll[31:0]});
            check_eq("stb_onehot", 64'($onehot(reconfig_to_pll[40:38])), 64'd1);
            check_eq("stb_upper_zero", 64'(reconfig_to_pll[63:41]), 64'd0);
            check_eq("stb_width", 64'(prev_stb), 64'd0);
        end
        if (prev_busy && !busy) fq.push_back(cyc);
        prev_stb  <= any_stb;
        prev_busy <= busy;
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        int unsigned n = 0;
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        while (avs_waitrequest && n < 2000) begin @(negedge clk); n++; end
        if (avs_waitrequest) check_eq("wr_stall", 64'(avs_waitrequest), 64'd0);
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int unsigned c);
        int unsigned n = 0;
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        while (avs_waitrequest && n < 2000) begin @(negedge clk); n++; end
        if (avs_waitrequest) check_eq("rd_stall", 64'(avs_waitrequest), 64'd0);
        c = cyc;
        @(negedge clk);
        d = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (avs_waitrequest && n < 3000) begin @(negedge clk); n++; end
        check_eq(tag, 64'(avs_waitrequest), 64'd0);
    endtask

    logic [31:0] rd;
    int unsigned rc;
    int unsigned s_cyc;
    logic [31:0] cw [5];

    initial begin
        cw[0] = 32'hFF84_0203;  // high junk bits must not reach the PLL
        cw[1] = 32'h0008_0404;
        cw[2] = 32'h000C_0605;
        cw[3] = 32'h0010_0806;
        cw[4] = 32'h0014_0A0A;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_readdata", 64'(avs_readdata), 64'd0);
        check_eq("rst_waitreq", 64'(avs_waitrequest), 64'd0);
        check_eq("rst_to_pll", reconfig_to_pll, 64'd0);
        rst = 1'b0;
        bus_read(3'd1, rd, rc);
        check_eq("rst_status", 64'(rd), 64'h0);
        bus_read(3'd0, rd, rc);
        check_eq("rst_mode", 64'(rd), 64'h0);

        // N/M commit in waitrequest mode
        stq.delete();
        busy_len = 3;
        bus_write(3'd3, 32'h0000_0505);
        bus_write(3'd4, 32'h0000_4847);
        bus_read(3'd3, rd, rc);
        check_eq("n_readback", 64'(rd), 64'h505);
        bus_read(3'd4, rd, rc);
        check_eq("m_readback", 64'(rd), 64'h4847);
        bus_write(3'd2, 32'h0);
        check_eq("start_wreq_hi", 64'(avs_waitrequest), 64'd1);
        wait_idle("commit_done");
        check_eq("locked_at_release", 64'(reconfig_from_pll[1]), 64'd1);
        check_eq("commit_nstb", 64'(stq.size()), 64'd3);
        if (stq.size() == 3) begin
            check_eq("n_kind", 64'(stq[0].kind), 64'b001);
            check_eq("n_addr", 64'(stq[0].addr), 64'd3);
            check_eq("n_data", 64'(stq[0].data), 64'h505);
            check_eq("m_kind", 64'(stq[1].kind), 64'b001);
            check_eq("m_addr", 64'(stq[1].addr), 64'd4);
            check_eq("m_data", 64'(stq[1].data), 64'h4847);
            check_eq("start_kind", 64'(stq[2].kind), 64'b010);
        end
        bus_read(3'd1, rd, rc);
        check_eq("status_locked", 64'(rd), 64'h2);

        // C FIFO overflow, ordered drain of the first four entries
        stq.delete();
        for (int i = 0; i < 5; i++) bus_write(3'd5, cw[i]);
        bus_read(3'd1, rd, rc);
        check_eq("status_ovf", 64'(rd), 64'hA);
        bus_write(3'd2, 32'h0);
        wait_idle("c_commit_done");
        check_eq("c_nstb", 64'(stq.size()), 64'd5);
        if (stq.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("c_kind", 64'(stq[i].kind), 64'b001);
                check_eq("c_addr", 64'(stq[i].addr), 64'd5);
                check_eq("c_data", 64'(stq[i].data), 64'({9'd0, cw[i][22:0]}));
            end
            check_eq("c_start_kind", 64'(stq[4].kind), 64'b010);
        end
        bus_read(3'd1, rd, rc);
        check_eq("ovf_sticky", 64'(rd), 64'hA);
        bus_write(3'd1, 32'h8);
        bus_read(3'd1, rd, rc);
        check_eq("ovf_cleared", 64'(rd), 64'h2);

        // Polling mode, PLL never relocks
        bus_write(3'd0, 32'h1);
        bus_read(3'd0, rd, rc);
        check_eq("mode_poll", 64'(rd), 64'h1);
        busy_len = 0;
        lock_en  = 1'b0;
        stq.delete();
        bus_write(3'd2, 32'h0);
        check_eq("poll_no_wreq", 64'(avs_waitrequest), 64'd0);
        bus_read(3'd1, rd, rc);
        check_eq("poll_busy", 64'(rd), 64'h1);
        bus_write(3'd3, 32'h0001_2345);
        for (int i = 0; i < 400; i++) begin
            bus_read(3'd1, rd, rc);
            if (!rd[0]) break;
        end
        check_eq("to_status", 64'(rd), 64'h4);
        check_eq("to_nstb", 64'(stq.size()), 64'd1);
        if (stq.size() == 1) begin
            s_cyc = stq[0].cyc;
            check_eq("to_window", 64'((rc >= s_cyc + LT) && (rc <= s_cyc + LT + 6)), 64'd1);
        end
        bus_read(3'd3, rd, rc);
        check_eq("n_write_ignored", 64'(rd), 64'h505);
        bus_write(3'd1, 32'h4);
        bus_read(3'd1, rd, rc);
        check_eq("to_cleared", 64'(rd), 64'h0);
        bus_write(3'd0, 32'h0);
        lock_en = 1'b1;

        // Phase steps, no busy from the PLL
        stq.delete();
        bus_write(3'd6, 32'h0023_0003);
        wait_idle("phase_done");
        check_eq("ph_nstb", 64'(stq.size()), 64'd3);
        if (stq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("ph_kind", 64'(stq[i].kind), 64'b100);
                check_eq("ph_addr", 64'(stq[i].addr), 64'd6);
                check_eq("ph_data", 64'(stq[i].data), 64'h0023_0000);
            end
            // launch cycle + BUSY_GAP cycles + one WAIT_BUSY cycle
            check_eq("ph_spacing1", 64'(stq[1].cyc - stq[0].cyc), 64'(BG + 2));
            check_eq("ph_spacing2", 64'(stq[2].cyc - stq[1].cyc), 64'(BG + 2));
        end

        // Zero step count: nothing happens
        stq.delete();
        bus_write(3'd6, 32'h0023_0000);
        check_eq("ph0_wreq", 64'(avs_waitrequest), 64'd0);
        repeat (10) @(negedge clk);
        check_eq("ph0_nstb", 64'(stq.size()), 64'd0);

        // Long busy: next strobe only after busy drops
        busy_len = 10;
        stq.delete();
        fq.delete();
        bus_write(3'd6, 32'h0005_0002);
        wait_idle("ph_busy_done");
        check_eq("phb_nstb", 64'(stq.size()), 64'd2);
        if (stq.size() == 2 && fq.size() >= 1) begin
            check_eq("phb_data", 64'(stq[1].data), 64'h0005_0000);
            check_eq("phb_after_fall", 64'((stq[1].cyc >= fq[0] + 1) && (stq[1].cyc <= fq[0] + 3)), 64'd1);
        end else begin
            check_eq("phb_fall_seen", 64'(fq.size()), 64'd1);
        end

        // Reset while waiting on busy
        busy_len = 50;
        lock_en  = 1'b0;
        stq.delete();
        bus_write(3'd3, 32'h0000_0777);
        bus_write(3'd2, 32'h0);
        for (int i = 0; i < 200 && stq.size() == 0; i++) @(negedge clk);
        check_eq("rst_mid_stb", 64'(stq.size()), 64'd1);
        repeat (4) @(negedge clk);
        check_eq("rst_mid_busy", 64'(avs_waitrequest), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_to_pll", reconfig_to_pll, 64'd0);
        check_eq("rst_mid_wreq", 64'(avs_waitrequest), 64'd0);
        check_eq("rst_mid_rdata", 64'(avs_readdata), 64'd0);
        rst = 1'b0;
        bus_read(3'd1, rd, rc);
        check_eq("rst_mid_status", 64'(rd), 64'h0);
        bus_read(3'd3, rd, rc);
        check_eq("rst_mid_n", 64'(rd), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Management-side controller for the reconfigurable Cyclone V PLL; drives the PLL's 64-bit reconfig_to_pll bus and consumes its 64-bit reconfig_from_pll bus.
- Exposes an Avalon-MM slave so the video controller's soft CPU can retune pixel and SDRAM clocks at run time.
- Holds shadow counter settings, commits them to the PLL as sequenced bus transactions on START, then waits for relock.
- Also issues dynamic phase-shift steps.

Parameters:
- C_FIFO_DEPTH, 4, depth of the pending C-counter write queue (power of 2, ≥2).
- LOCK_TIMEOUT, 65535, cycles to wait for `locked` after commit before flagging timeout.
- BUSY_GAP, 2, cycles after any PLL strobe before `from_pll` busy is sampled.

Ports:
- clk  in  1  management clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- avs_address  in  3  register index.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; valid the cycle after an accepted read.
- avs_waitrequest  out  1  stalls the master.
- reconfig_to_pll  out  64  [31:0] data, [37:32] PLL register address, [38] wr strobe, [39] start strobe, [40] phase strobe, [63:41] zero.
- reconfig_from_pll  in  64  [0] busy, [1] locked, [63:2] ignored.

Behaviour:
- Register map:
  - 0 MODE: bit0 = 0 waitrequest mode, 1 polling mode.
  - 1 STATUS (RO): bit0 fsm_busy, bit1 locked, bit2 timeout (sticky), bit3 c_overflow (sticky). Writing 1 to bit2/bit3 clears them.
  - 2 START (WO, any value).
  - 3 N: [17:0] shadow, sets n_dirty.
  - 4 M: [17:0] shadow, sets m_dirty.
  - 5 C: [22:18] counter select, [17:0] hi/lo; pushed to C FIFO.
  - 6 PHASE: [20:16] counter select, [21] up/down, [15:0] step count.
  - Reads of 3/4 return the shadow. Reads of 5/6 return 0.
- Reads are accepted when waitrequest=0; readdata is registered with 1-cycle latency.
- C FIFO full + write to reg 5: data is dropped and c_overflow is set. Simultaneous push and pop when full is allowed.
- FSM states: IDLE, ISSUE, GAP, WAIT_BUSY, START_PLS, WAIT_LOCK, PHASE_PLS.
- START in IDLE enters ISSUE. Order of issue: N if dirty, then M if dirty, then C FIFO entries in order.
  - Each issue drives a 1-cycle wr strobe with address (N=3, M=4, C=5) and data.
  - Then GAP for BUSY_GAP cycles, then WAIT_BUSY until busy=0.
  - The dirty flag clears or the FIFO pops on strobe.
- When nothing remains: START_PLS (1-cycle start strobe) → GAP → WAIT_BUSY → WAIT_LOCK.
- WAIT_LOCK: returns to IDLE when locked=1. Returns to IDLE with timeout=1 when the counter reaches LOCK_TIMEOUT.
- START with nothing dirty and FIFO empty still performs START_PLS.
- PHASE write in IDLE: issue `step count` phase strobes. Address=6, data={10'b0,up/down,select,16'b0}. Each strobe is followed by GAP and WAIT_BUSY. Step count 0 → no strobes.
- Waitrequest mode:
  - A START or PHASE write holds waitrequest=1 from acceptance until FSM returns to IDLE.
  - Any access while FSM≠IDLE stalls.
- Polling mode:
  - waitrequest=0 always.
  - Writes to 2–6 while FSM≠IDLE are ignored.
  - STATUS readable anytime.
- Strobes are exactly 1 cycle. `reconfig_to_pll` is zero outside strobe cycles except the data/address fields, which hold their last value.
- Reset values:
  - avs_readdata=0, avs_waitrequest=0, reconfig_to_pll=0.
  - Shadows 0, dirty flags 0, FIFO empty, sticky bits 0, MODE=0, FSM IDLE.
  - Reset mid-operation aborts immediately and applies the same values.

Test Plan:
- Write N=0x00505, M=0x04847, START in waitrequest mode → wr strobes addr 3 then 4 with those data, then start strobe. waitrequest=1 until model locked=1, then 0. STATUS=0x2.
- Push 5 C writes (depth 4) → STATUS bit3=1. START issues exactly 4 addr-5 strobes in write order. Write 0x8 to STATUS → bit3 clears.
- Polling mode: START with model never locking → STATUS bit0=1 for LOCK_TIMEOUT cycles, then bit0=0 and bit2=1. A write to N during this window leaves the shadow unchanged.
- PHASE=0x00230003 → 3 phase strobes, each followed by BUSY_GAP cycles then a wait for busy=0. Data field=0x00230000.
- Model busy held high 10 cycles after each strobe → next strobe occurs no earlier than the cycle after busy falls.
- Assert rst during WAIT_BUSY → next cycle reconfig_to_pll=0, waitrequest=0, STATUS=0, N readback=0.
